// File: rtl/mat_sigmoid_grad.sv
// Elementwise sigmoid backward pass Z = G * Y * (1 - Y), serialized through one adder and one multiplier.
// Define MAT_SIGMOID_GRAD_ZERO_SKIP_EN to bypass the cores for elements whose gradient is +/-0.

module float_core #(
    parameter bit IS_MUL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        in_stb,
    output logic        in_ack,
    output logic [31:0] z,
    output logic        z_stb,
    input  logic        z_ack
);
    typedef enum logic [1:0] {C_IDLE, C_CALC, C_PUT} core_state_t;

    core_state_t state;
    logic [31:0] a_q, b_q;

    // Denormals flush to zero; exponent 255 is not special-cased.
    function automatic logic [31:0] fadd(input logic [31:0] a_in, input logic [31:0] b_in);
        logic [31:0]       x, y;
        logic [7:0]        d;
        logic [26:0]       my;
        logic [27:0]       s;
        logic [23:0]       r;
        logic signed [9:0] e;
        if (a_in[30:23] == 8'd0) return (b_in[30:23] == 8'd0) ? {a_in[31] & b_in[31], 31'd0} : b_in;
        if (b_in[30:23] == 8'd0) return a_in;
        if (a_in[30:0] >= b_in[30:0]) begin x = a_in; y = b_in; end
        else begin x = b_in; y = a_in; end
        d  = x[30:23] - y[30:23];
        my = {1'b1, y[22:0], 3'b000};
        for (int i = 0; i < 27; i++)
            if (i < int'(d)) my = {1'b0, my[26:2], my[1] | my[0]};
        e = $signed({2'b00, x[30:23]});
        if (x[31] == y[31]) s = {2'b01, x[22:0], 3'b000} + {1'b0, my};
        else                s = {2'b01, x[22:0], 3'b000} - {1'b0, my};
        if (s == 28'd0) return 32'd0;
        if (s[27]) begin
            s = {1'b0, s[27:2], s[1] | s[0]};
            e = e + 10'sd1;
        end
        for (int i = 0; i < 26; i++)
            if (!s[26]) begin s = {s[26:0], 1'b0}; e = e - 10'sd1; end
        r = {1'b0, s[25:3]} + {23'd0, s[2] & (s[1] | s[0] | s[3])};
        if (r[23]) e = e + 10'sd1;
        if (e <= 10'sd0)   return {x[31], 31'd0};
        if (e >= 10'sd255) return {x[31], 8'hff, 23'd0};
        return {x[31], e[7:0], r[22:0]};
    endfunction

    function automatic logic [31:0] fmul(input logic [31:0] a_in, input logic [31:0] b_in);
        logic              sg;
        logic [47:0]       p;
        logic [22:0]       f;
        logic              rnd;
        logic [23:0]       r;
        logic signed [9:0] e;
        sg = a_in[31] ^ b_in[31];
        if (a_in[30:23] == 8'd0 || b_in[30:23] == 8'd0) return {sg, 31'd0};
        p = {24'd0, 1'b1, a_in[22:0]} * {24'd0, 1'b1, b_in[22:0]};
        e = $signed({2'b00, a_in[30:23]}) + $signed({2'b00, b_in[30:23]}) - 10'sd127;
        if (p[47]) begin
            f   = p[46:24];
            rnd = p[23] & ((|p[22:0]) | p[24]);
            e   = e + 10'sd1;
        end else begin
            f   = p[45:23];
            rnd = p[22] & ((|p[21:0]) | p[23]);
        end
        r = {1'b0, f} + {23'd0, rnd};
        if (r[23]) e = e + 10'sd1;
        if (e <= 10'sd0)   return {sg, 31'd0};
        if (e >= 10'sd255) return {sg, 8'hff, 23'd0};
        return {sg, e[7:0], r[22:0]};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= C_IDLE;
            in_ack <= 1'b0;
            z_stb  <= 1'b0;
            z      <= '0;
            a_q    <= '0;
            b_q    <= '0;
        end else begin
            case (state)
                C_IDLE: begin
                    in_ack <= 1'b1;
                    if (in_stb && in_ack) begin
                        a_q    <= a;
                        b_q    <= b;
                        in_ack <= 1'b0;
                        state  <= C_CALC;
                    end
                end
                C_CALC: begin
                    z     <= IS_MUL ? fmul(a_q, b_q) : fadd(a_q, b_q);
                    z_stb <= 1'b1;
                    state <= C_PUT;
                end
                C_PUT: begin
                    if (z_stb && z_ack) begin
                        z_stb <= 1'b0;
                        state <= C_IDLE;
                    end
                end
                default: state <= C_IDLE;
            endcase
        end
    end
endmodule

// state        | meaning
// GET_INPUT    | waiting for Y/G, input_mat_ack high
// SUB          | t = 1 - Y[k] on the adder
// MUL_YT       | p = Y[k] * t on the multiplier
// MUL_G        | Z[k] = p * G[k] on the multiplier
// NEXT         | advance k or finish
// PUT_OUTPUT   | presenting Z, output_mat_stb high
module mat_sigmoid_grad #(
    parameter int M = 2,
    parameter int N = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [M-1:0][N-1:0][31:0] input_mat,
    input  logic [M-1:0][N-1:0][31:0] input_grad,
    input  logic                      input_mat_stb,
    output logic                      input_mat_ack,
    output logic [M-1:0][N-1:0][31:0] output_mat,
    output logic                      output_mat_stb,
    input  logic                      output_mat_ack
);
    localparam int            E      = M * N;
    localparam int            KW     = (E > 1) ? $clog2(E) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(E - 1);
    localparam logic [31:0]   ONE    = 32'h3f800000;

    typedef enum logic [2:0] {S_GET_INPUT, S_SUB, S_MUL_YT, S_MUL_G, S_NEXT, S_PUT_OUTPUT} state_t;

    state_t             state;
    logic [KW-1:0]      k;
    logic [E-1:0][31:0] y_q, g_q, z_q;
    logic [31:0]        t_q, p_q, y_k, g_k;
    logic               busy;
    logic               add_stb, add_in_ack, add_z_stb, add_z_ack;
    logic [31:0]        add_z;
    logic               mul_stb, mul_in_ack, mul_z_stb, mul_z_ack;
    logic [31:0]        mul_a, mul_b, mul_z;

    assign y_k        = y_q[k];
    assign g_k        = g_q[k];
    assign mul_a      = (state == S_MUL_G) ? p_q : y_k;
    assign mul_b      = (state == S_MUL_G) ? g_k : t_q;
    assign output_mat = z_q;

    float_core #(.IS_MUL(1'b0)) u_adder (
        .clk(clk), .rst(rst), .a(ONE), .b({~y_k[31], y_k[30:0]}),
        .in_stb(add_stb), .in_ack(add_in_ack),
        .z(add_z), .z_stb(add_z_stb), .z_ack(add_z_ack)
    );

    float_core #(.IS_MUL(1'b1)) u_multiplier (
        .clk(clk), .rst(rst), .a(mul_a), .b(mul_b),
        .in_stb(mul_stb), .in_ack(mul_in_ack),
        .z(mul_z), .z_stb(mul_z_stb), .z_ack(mul_z_ack)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_GET_INPUT;
            k              <= '0;
            input_mat_ack  <= 1'b0;
            output_mat_stb <= 1'b0;
            y_q            <= '0;
            g_q            <= '0;
            z_q            <= '0;
            t_q            <= '0;
            p_q            <= '0;
            busy           <= 1'b0;
            add_stb        <= 1'b0;
            add_z_ack      <= 1'b0;
            mul_stb        <= 1'b0;
            mul_z_ack      <= 1'b0;
        end else begin
            case (state)
                S_GET_INPUT: begin
                    input_mat_ack <= 1'b1;
                    if (input_mat_stb && input_mat_ack) begin
                        y_q           <= input_mat;
                        g_q           <= input_grad;
                        k             <= '0;
                        input_mat_ack <= 1'b0;
                        state         <= S_SUB;
                    end
                end
                S_SUB: begin
`ifdef MAT_SIGMOID_GRAD_ZERO_SKIP_EN
                    if (!busy && g_k[30:0] == 31'd0) begin
                        z_q[k] <= 32'd0;
                        state  <= S_NEXT;
                    end else
`endif
                    if (!busy) begin
                        add_stb <= 1'b1;
                        busy    <= 1'b1;
                    end else begin
                        if (add_stb && add_in_ack) add_stb <= 1'b0;
                        if (add_z_stb && add_z_ack) begin
                            t_q       <= add_z;
                            add_z_ack <= 1'b0;
                            busy      <= 1'b0;
                            state     <= S_MUL_YT;
                        end else if (add_z_stb) begin
                            add_z_ack <= 1'b1;
                        end
                    end
                end
                S_MUL_YT, S_MUL_G: begin
                    if (!busy) begin
                        mul_stb <= 1'b1;
                        busy    <= 1'b1;
                    end else begin
                        if (mul_stb && mul_in_ack) mul_stb <= 1'b0;
                        if (mul_z_stb && mul_z_ack) begin
                            mul_z_ack <= 1'b0;
                            busy      <= 1'b0;
                            if (state == S_MUL_YT) begin
                                p_q   <= mul_z;
                                state <= S_MUL_G;
                            end else begin
                                z_q[k] <= mul_z;
                                state  <= S_NEXT;
                            end
                        end else if (mul_z_stb) begin
                            mul_z_ack <= 1'b1;
                        end
                    end
                end
                S_NEXT: begin
                    if (k == K_LAST) begin
                        output_mat_stb <= 1'b1;
                        state          <= S_PUT_OUTPUT;
                    end else begin
                        k     <= k + 1'b1;
                        state <= S_SUB;
                    end
                end
                S_PUT_OUTPUT: begin
                    if (output_mat_stb && output_mat_ack) begin
                        output_mat_stb <= 1'b0;
                        input_mat_ack  <= 1'b1;
                        state          <= S_GET_INPUT;
                    end
                end
                default: state <= S_GET_INPUT;
            endcase
        end
    end
endmodule

// File: tb/tb_mat_sigmoid_grad.sv
// Scoreboard bench for mat_sigmoid_grad: expected matrices come from real-valued arithmetic on exactly
// representable operands; a negedge monitor checks every output handshake. Honors MAT_SIGMOID_GRAD_ZERO_SKIP_EN.

module tb_mat_sigmoid_grad;
    localparam int M = 2;
    localparam int N = 3;
    localparam int E = M * N;
    localparam logic [31:0] H05  = 32'h3f000000;
    localparam logic [31:0] H10  = 32'h3f800000;
    localparam logic [31:0] QRTR = 32'h3e800000;

    typedef logic [E-1:0][31:0] mat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    mat_t input_mat, input_grad, out_mat;
    logic input_mat_stb, input_mat_ack, output_mat_stb, output_mat_ack;

    mat_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   ack_mode = 0;

    mat_sigmoid_grad #(.M(M), .N(N)) dut (
        .clk(clk), .rst(rst),
        .input_mat(input_mat), .input_grad(input_grad),
        .input_mat_stb(input_mat_stb), .input_mat_ack(input_mat_ack),
        .output_mat(out_mat), .output_mat_stb(output_mat_stb),
        .output_mat_ack(output_mat_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input mat_t act, input mat_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    function automatic real pow2(input int e);
        real v = 1.0;
        for (int i = 0; i < e; i++) v = v * 2.0;
        for (int i = 0; i > e; i--) v = v / 2.0;
        return v;
    endfunction

    function automatic real f2r(input logic [31:0] f);
        real m;
        if (f[30:23] == 8'd0) return 0.0;
        m = (1.0 + real'(f[22:0]) / 8388608.0) * pow2(int'(f[30:23]) - 127);
        return f[31] ? -m : m;
    endfunction

    // Exact only for values representable in single precision, which all stimulus is built to be.
    function automatic logic [31:0] r2f(input real x, input logic zsign);
        logic [63:0] d;
        if (x == 0.0) return {zsign, 31'd0};
        d = $realtobits(x);
        return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
    endfunction

    function automatic mat_t model(input mat_t y, input mat_t g);
        mat_t z;
        real  yv, gv;
        for (int k = 0; k < E; k++) begin
            yv = f2r(y[k]);
            gv = f2r(g[k]);
`ifdef MAT_SIGMOID_GRAD_ZERO_SKIP_EN
            if (g[k][30:0] == 31'd0) z[k] = 32'd0;
            else
`endif
            z[k] = r2f(gv * yv * (1.0 - yv), g[k][31] ^ y[k][31]);
        end
        return z;
    endfunction

    function automatic mat_t fill(input logic [31:0] v);
        mat_t z;
        for (int k = 0; k < E; k++) z[k] = v;
        return z;
    endfunction

    initial begin
        output_mat_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ack_mode)
                0:       output_mat_ack = ($urandom_range(0, 3) != 0);
                1:       output_mat_ack = 1'b0;
                default: output_mat_ack = 1'b1;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst && output_mat_stb && output_mat_ack) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: got %h expected no output", out_mat);
            end else begin
                check("output_mat", out_mat, sb.pop_front());
            end
        end
    end

    task automatic send(input mat_t y, input mat_t g, input mat_t expv, input bit push, output int t_xfer);
        int t = 0;
        @(posedge clk);
        #1;
        input_mat     = y;
        input_grad    = g;
        input_mat_stb = 1'b1;
        while (input_mat_ack !== 1'b1 && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 3000) begin
            timeout_fail("input_accept");
            input_mat_stb = 1'b0;
            t_xfer = cyc;
            return;
        end
        if (push) sb.push_back(expv);
        @(posedge clk);
        #1;
        t_xfer = cyc;
        check_bit("input_ack_falls", input_mat_ack, 1'b0);
        input_mat_stb = 1'b0;
        for (int k = 0; k < E; k++) begin
            input_mat[k]  = $urandom();
            input_grad[k] = $urandom();
        end
    endtask

    task automatic wait_stb(output bit ok);
        int t = 0;
        ok = 1'b1;
        while (output_mat_stb !== 1'b1) begin
            @(negedge clk);
            t++;
            if (t > 3000) begin
                ok = 1'b0;
                timeout_fail("wait_output_stb");
                return;
            end
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!(sb.size() == 0 && input_mat_ack === 1'b1 && output_mat_stb === 1'b0)) begin
            @(negedge clk);
            t++;
            if (t > 5000) begin
                timeout_fail("wait_idle");
                return;
            end
        end
    endtask

    initial begin
        mat_t y, g, ex, snap;
        int   t, tw, lat, a, b, s;
        bit   ok, stable;
        real  gv;

        input_mat     = '0;
        input_grad    = '0;
        input_mat_stb = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_bit("reset_in_ack", input_mat_ack, 1'b0);
        check_bit("reset_out_stb", output_mat_stb, 1'b0);
        check("reset_out_mat", out_mat, '0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 check_bit("in_ack_after_reset", input_mat_ack, 1'b1);

        send(fill(H05), fill(H10), fill(QRTR), 1'b1, t);
        wait_idle();
        send(fill(32'h3f400000), fill(32'h40000000), fill(32'h3ec00000), 1'b1, t);
        send(fill(32'h3e800000), fill(32'hbf800000), fill(32'hbe400000), 1'b1, t);
        wait_idle();

        y = fill(H05);
        y[0] = H10;
        ex = fill(QRTR);
        ex[0] = 32'h00000000;
        send(y, fill(H10), ex, 1'b1, t);
        wait_idle();

        ack_mode = 1;
        send(fill(H05), fill(H10), fill(QRTR), 1'b1, t);
        wait_stb(ok);
        if (ok) begin
            snap   = out_mat;
            stable = 1'b1;
            input_mat_stb = 1'b1;
            for (int k = 0; k < E; k++) input_mat[k] = $urandom();
            repeat (50) begin
                @(negedge clk);
                if (output_mat_stb !== 1'b1 || out_mat !== snap || input_mat_ack !== 1'b0) stable = 1'b0;
            end
            input_mat_stb = 1'b0;
            check_bit("hold_stable", stable, 1'b1);
            ack_mode = 2;
            @(posedge clk);
            #2;
            @(posedge clk);
            #2;
            check_bit("stb_falls_after_ack", output_mat_stb, 1'b0);
            check_bit("in_ack_rises_after_ack", input_mat_ack, 1'b1);
        end
        ack_mode = 0;
        wait_idle();

        repeat (20) begin
            for (int k = 0; k < E; k++) begin
                a = $urandom_range(1, 255);
                y[k] = r2f(real'(a) / 256.0, 1'b0);
                b = $urandom_range(1, 255);
                s = $urandom_range(0, 12);
                gv = real'(b) / 128.0 * pow2(s - 10);
                if ($urandom_range(0, 1) == 1) gv = -gv;
                g[k] = r2f(gv, 1'b0);
            end
            send(y, g, model(y, g), 1'b1, t);
        end
        wait_idle();

        send(fill(H05), fill(H10), '0, 1'b0, t);
        tw = 0;
        while (dut.k != 3 && tw < 3000) begin
            @(posedge clk);
            #1;
            tw++;
        end
        if (tw >= 3000) timeout_fail("wait_element_3");
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check_bit("midrun_rst_in_ack", input_mat_ack, 1'b0);
        check_bit("midrun_rst_out_stb", output_mat_stb, 1'b0);
        check("midrun_rst_out_mat", out_mat, '0);
        send(fill(H05), fill(H10), fill(QRTR), 1'b1, t);
        wait_idle();

        send(fill(H05), fill(32'h80000000), model(fill(H05), fill(32'h80000000)), 1'b1, t);
        wait_stb(ok);
`ifdef MAT_SIGMOID_GRAD_ZERO_SKIP_EN
        lat = cyc - t;
        n_cmp++;
        if (!ok || lat > 2 * E + 2) begin
            n_err++;
            $display("FAIL zero_skip_latency: got %0d cycles expected at most %0d", lat, 2 * E + 2);
        end
`else
        lat = 0;
`endif
        wait_idle();
        check_bit("scoreboard_drained", sb.size() == 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
